// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - boot-sequenced arbiter sharing a 1-cycle BRAM imem between fetch and loader
// Optional: define IMEM_WRITE_PROTECT_EN to turn loader writes in RUN into rejected (err) accesses.
module imem_arbiter #(
  parameter int DEPTH      = 512,
  parameter int AW         = $clog2(DEPTH),
  parameter int STARVE_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_boot_done,
  input  logic          i_if_req,
  input  logic [31:0]   i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [31:0]   o_if_rdata,
  output logic          o_if_fault,
  input  logic          i_ld_req,
  input  logic          i_ld_we,
  input  logic [31:0]   i_ld_addr,
  input  logic [31:0]   i_ld_wdata,
  output logic          o_ld_gnt,
  output logic          o_ld_rvalid,
  output logic [31:0]   o_ld_rdata,
  output logic          o_ld_err,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata,
  output logic          o_boot_mode,
  output logic          o_cpu_stall
);

  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_SAT = SW'(STARVE_MAX);
  localparam logic [31:0]     NOP        = 32'h0000_0013;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rvalid_q, rvalid_d;
  logic          owner_q, owner_d;   // 0: fetch issued the pending read, 1: loader
  logic          bad_q, bad_d;
  logic          ld_err_q, ld_err_d;

  logic          if_ok, ld_ok, ld_blocked, starved;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> (AW + 2)) == 32'd0);
  endfunction

  assign if_ok   = addr_ok(i_if_addr);
  assign ld_ok   = addr_ok(i_ld_addr);
  assign starved = (starve_q == STARVE_SAT);

`ifdef IMEM_WRITE_PROTECT_EN
  assign ld_blocked = (state_q == ST_RUN) & i_ld_we;
`else
  assign ld_blocked = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    o_if_gnt = 1'b0;
    o_ld_gnt = 1'b0;
    case (state_q)
      ST_BOOT: begin
        o_ld_gnt = i_ld_req;
        if (i_boot_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        o_if_gnt = i_if_req & ~(i_ld_req & starved);
        o_ld_gnt = i_ld_req & ~o_if_gnt;
      end
      default: state_d = ST_BOOT;
    endcase
    if (i_reset) begin
      o_if_gnt = 1'b0;
      o_ld_gnt = 1'b0;
    end
  end

  // Bad addresses are still granted so the requester always gets a response.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    rvalid_d    = 1'b0;
    owner_d     = owner_q;
    bad_d       = 1'b0;
    ld_err_d    = 1'b0;
    if (o_if_gnt) begin
      o_mem_en   = if_ok;
      o_mem_addr = i_if_addr[AW+1:2];
      rvalid_d   = 1'b1;
      owner_d    = 1'b0;
      bad_d      = ~if_ok;
    end else if (o_ld_gnt) begin
      o_mem_addr = i_ld_addr[AW+1:2];
      if (i_ld_we) begin
        o_mem_en    = ld_ok & ~ld_blocked;
        o_mem_we    = ld_ok & ~ld_blocked;
        o_mem_wdata = i_ld_wdata;
        ld_err_d    = ~ld_ok | ld_blocked;
      end else begin
        o_mem_en = ld_ok;
        rvalid_d = 1'b1;
        owner_d  = 1'b1;
        bad_d    = ~ld_ok;
        ld_err_d = ~ld_ok;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if ((state_q == ST_BOOT) || o_ld_gnt) begin
      starve_d = '0;
    end else if (i_ld_req && !starved) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_BOOT;
      starve_q <= '0;
      rvalid_q <= 1'b0;
      owner_q  <= 1'b0;
      bad_q    <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rvalid_q <= rvalid_d;
      owner_q  <= owner_d;
      bad_q    <= bad_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign o_if_rvalid = rvalid_q & ~owner_q;
  assign o_ld_rvalid = rvalid_q & owner_q;
  assign o_if_rdata  = o_if_rvalid ? (bad_q ? NOP : i_mem_rdata) : '0;
  assign o_ld_rdata  = o_ld_rvalid ? (bad_q ? NOP : i_mem_rdata) : '0;
  assign o_if_fault  = o_if_rvalid & bad_q;
  assign o_ld_err    = ld_err_q;
  assign o_boot_mode = (state_q == ST_BOOT);
  assign o_cpu_stall = i_if_req & ~o_if_gnt;

endmodule
